mmio_bridge: RTL and testbench

Load/store bridge between the CPU data-memory port and its two targets: the word-wide synchronous data memory and the PDU IO bus. It decodes each access by address, sequences sub-word stores as read-modify-write on the data memory, aligns and sign/zero-extends load data, and guarantees that every IO load produces exactly one `io_rd` pulse, so the PDU's read-clears-valid logic fires once per load. It sits in the CPU's MEM stage and is clocked by the CPU clock, so single-step and breakpoint control from the PDU apply to it unchanged.

---
 rtl/mmio_bridge_pkg.sv | 38 +++
 rtl/mmio_bridge_lsu_lane.sv | 59 +++++
 rtl/mmio_bridge.sv | 147 ++++++++++++++
 tb/tb_mmio_bridge.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_bridge_pkg.sv
// Shared types for the CPU load/store bridge: FSM states, access size codes, IO window default.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bridge_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    IO_WAIT = 2'd2,
    RMW_WR  = 2'd3
  } state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  localparam logic [31:0] IO_BASE_DEF = 32'h0000_7F00;

  // Request fields that must survive the stall cycle of a 2-cycle access
  typedef struct packed {
    logic [1:0]  lane;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
  } req_t;

  // Size code is legal and the byte offset suits it
  function automatic logic aligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_B:    return 1'b1;
      SZ_H:    return ~lo[0];
      SZ_W:    return (lo == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mmio_bridge_lsu_lane.sv
// Lane logic: extracts and extends a load from a memory word, and merges sub-word store data into one.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the results are used.
module lsu_lane
  import bridge_pkg::*;
(
  input  logic [31:0] rword,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic [31:0] mword
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte and half out of the word
  always_comb begin
    case (lane)
      2'd0:    byte_sel = rword[7:0];
      2'd1:    byte_sel = rword[15:8];
      2'd2:    byte_sel = rword[23:16];
      default: byte_sel = rword[31:24];
    endcase
    half_sel = lane[1] ? rword[31:16] : rword[15:0];
  end

  // Sign- or zero-extend the selected lane to a full word
  always_comb begin
    case (size)
      SZ_B:    ldata = {{24{byte_sel[7] & ~uns}}, byte_sel};
      SZ_H:    ldata = {{16{half_sel[15] & ~uns}}, half_sel};
      default: ldata = rword;
    endcase
  end

  // Replace the addressed lane of the old word with the low store bits
  always_comb begin
    mword = rword;
    case (size)
      SZ_B: begin
        case (lane)
          2'd0:    mword[7:0]   = wdata[7:0];
          2'd1:    mword[15:8]  = wdata[7:0];
          2'd2:    mword[23:16] = wdata[7:0];
          default: mword[31:24] = wdata[7:0];
        endcase
      end
      SZ_H: begin
        if (lane[1]) mword[31:16] = wdata[15:0];
        else         mword[15:0]  = wdata[15:0];
      end
      default: mword = wdata;
    endcase
  end

endmodule

// File: rtl/mmio_bridge.sv
// CPU load/store bridge to word-wide sync data memory and the PDU IO bus, with sub-word RMW.
// Latency: word/IO stores 1 cycle; loads and sub-word stores 2 cycles (result valid in the 2nd).
// Backpressure: stall held high for exactly one cycle on 2-cycle accesses; requests only accepted in IDLE.
module mmio_bridge
  import bridge_pkg::*;
#(
  parameter int          DM_AW   = 8,
  parameter logic [31:0] IO_BASE = IO_BASE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic              mem_we,
  input  logic              mem_re,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  output logic [31:0]       mem_rdata,
  output logic              stall,
  output logic              err,
  output logic [DM_AW-1:0]  dm_addr,
  output logic [31:0]       dm_wdata,
  output logic              dm_we,
  input  logic [31:0]       dm_rdata,
  output logic [7:0]        io_addr,
  output logic [31:0]       io_dout,
  output logic              io_we,
  output logic              io_rd,
  input  logic [31:0]       io_din
);

  state_t            state, state_nx;
  req_t              req_q;
  logic [DM_AW-1:0]  waddr_q;
  logic [31:0]       hold_q;
  logic              err_q;

  logic        accept_win;
  logic        req_any, conflict, is_io, legal, ok, bad;
  logic        ok_io_st, ok_io_ld, ok_dm_wst, ok_dm_sub, ok_dm_ld;
  logic [31:0] lane_ldata, lane_mword;

  // Decode the presented request; only IDLE outside reset may accept one
  always_comb begin
    accept_win = (state == IDLE) && !rst;
    req_any    = mem_we | mem_re;
    conflict   = mem_we & mem_re;
    is_io      = (mem_addr[31:8] == IO_BASE[31:8]);
    legal      = aligned(mem_size, mem_addr[1:0]) && !(is_io && (mem_size != SZ_W));
    ok         = accept_win & req_any & ~conflict & legal;
    bad        = accept_win & req_any & (conflict | ~legal);
    ok_io_st   = ok & is_io & mem_we;
    ok_io_ld   = ok & is_io & mem_re;
    ok_dm_wst  = ok & ~is_io & mem_we & (mem_size == SZ_W);
    ok_dm_sub  = ok & ~is_io & mem_we & (mem_size != SZ_W);
    ok_dm_ld   = ok & ~is_io & mem_re;
  end

  lsu_lane u_lane (
    .rword (dm_rdata),
    .lane  (req_q.lane),
    .size  (req_q.size),
    .uns   (req_q.uns),
    .wdata (req_q.wdata),
    .ldata (lane_ldata),
    .mword (lane_mword)
  );

  // State register; reset abandons any pending RMW write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state: every 2-cycle access returns to IDLE after its second cycle
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (ok_io_ld)       state_nx = IO_WAIT;
        else if (ok_dm_ld)  state_nx = RD_WAIT;
        else if (ok_dm_sub) state_nx = RMW_WR;
        else                state_nx = IDLE;
      end
      RD_WAIT: state_nx = IDLE;
      IO_WAIT: state_nx = IDLE;
      RMW_WR:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs: strobes only in the IDLE request cycle, except the RMW write-back
  always_comb begin
    stall     = 1'b0;
    dm_we     = 1'b0;
    io_we     = 1'b0;
    io_rd     = 1'b0;
    dm_wdata  = mem_wdata;
    dm_addr   = mem_addr[DM_AW+1:2];
    mem_rdata = hold_q;
    case (state)
      IDLE: begin
        io_we = ok_io_st;
        io_rd = ok_io_ld;
        dm_we = ok_dm_wst;
        stall = ok_io_ld | ok_dm_ld | ok_dm_sub;
      end
      RD_WAIT: mem_rdata = lane_ldata;
      IO_WAIT: mem_rdata = hold_q;
      RMW_WR: begin
        dm_addr  = waddr_q;
        dm_wdata = lane_mword;
        dm_we    = 1'b1;
      end
      default: ;
    endcase
  end

  assign io_addr = mem_addr[7:0];
  assign io_dout = mem_wdata;
  assign err     = err_q;

  // Capture the request fields needed by the second cycle of a DM access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q   <= '0;
      waddr_q <= '0;
    end else if (ok_dm_ld || ok_dm_sub) begin
      req_q   <= '{lane: mem_addr[1:0], size: mem_size, uns: mem_unsigned, wdata: mem_wdata};
      waddr_q <= mem_addr[DM_AW+1:2];
    end
  end

  // Load-hold register: IO data at the strobe, DM data as it is returned
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  hold_q <= '0;
    else if (ok_io_ld)        hold_q <= io_din;
    else if (state == RD_WAIT) hold_q <= lane_ldata;
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      err_q <= 1'b0;
    else if (bad) err_q <= 1'b1;
  end

endmodule

// File: tb/tb_mmio_bridge.sv
// Bench for mmio_bridge: directed cases from the bring-up list plus randomized accesses vs a word-array model.
// Latency: checks 1-cycle stores and 2-cycle loads/sub-word stores cycle by cycle.
// Backpressure: models the CPU holding its request while stall is high.
module tb_mmio_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, dm_wdata, dm_rdata, io_dout, io_din;
  logic        mem_we, mem_re, mem_unsigned, stall, err, dm_we, io_we, io_rd;
  logic [1:0]  mem_size;
  logic [7:0]  dm_addr, io_addr;

  logic [31:0] dmem    [256];
  logic [31:0] ref_mem [256];
  logic [31:0] ref_hold;
  logic        ref_err;
  int          n_vec = 0;
  int          n_err = 0;

  mmio_bridge #(.DM_AW(8), .IO_BASE(32'h0000_7F00)) dut (
    .clk(clk), .rst(rst),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned), .mem_rdata(mem_rdata),
    .stall(stall), .err(err),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_rdata(dm_rdata),
    .io_addr(io_addr), .io_dout(io_dout), .io_we(io_we), .io_rd(io_rd), .io_din(io_din)
  );

  always #5 clk = ~clk;

  // Synchronous word memory, read data one cycle after the address
  always @(posedge clk) begin
    if (dm_we === 1'b1) dmem[dm_addr] <= dm_wdata;
    dm_rdata <= dmem[dm_addr];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Expected load value from a word, by arithmetic on the byte offset
  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] off,
                                             input logic [1:0] sz, input logic u);
    logic [31:0] v;
    if (sz == 2'b00) begin
      v = (w >> (8 * off)) % 256;
      if (!u && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      v = (w >> (8 * off)) % 65536;
      if (!u && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  // Expected word after a store of the given size at the given offset
  function automatic logic [31:0] model_store(input logic [31:0] w, input logic [1:0] off,
                                              input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] mask;
    if (sz == 2'b00) begin
      mask = 32'hFF << (8 * off);
      return (w & ~mask) | ((wd % 256) << (8 * off));
    end else if (sz == 2'b01) begin
      mask = 32'hFFFF << (8 * off);
      return (w & ~mask) | ((wd % 65536) << (8 * off));
    end
    return wd;
  endfunction

  task automatic drive(input logic we, input logic re, input logic [31:0] a, input logic [1:0] sz,
                       input logic u, input logic [31:0] wd);
    mem_we = we; mem_re = re; mem_addr = a; mem_size = sz; mem_unsigned = u; mem_wdata = wd;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 2'b10, 1'b0, 32'h0);
    @(negedge clk);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    chk("rst_rdata", mem_rdata, 32'h0);
    chk("rst_strobes", {29'b0, dm_we, io_we, io_rd}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    ref_err = 1'b0;
    ref_hold = 32'h0;
  endtask

  // One CPU access: drive, check every cycle, update the model, then one idle cycle
  task automatic access(input logic we, input logic re, input logic [31:0] a, input logic [1:0] sz,
                        input logic u, input logic [31:0] wd, input logic [31:0] iod,
                        output logic [31:0] got);
    logic io, bad, two;
    logic [7:0]  idx;
    logic [31:0] exp_ld;
    io  = (a[31:8] == 24'h00_007F);
    idx = a[9:2];
    bad = (we && re) || (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
          (sz == 2'b10 && a[1:0] != 2'b00) || (io && sz != 2'b10);
    bad = bad && (we || re);
    two = !bad && (re || (we && !io && sz != 2'b10));
    got = 32'h0;

    @(posedge clk); #1;
    drive(we, re, a, sz, u, wd);
    io_din = iod;
    @(negedge clk);
    chk("req_err", {31'b0, err}, {31'b0, ref_err});
    chk("req_rdata_hold", mem_rdata, ref_hold);
    if (!(we || re) || bad) begin
      chk("req_idle_stall", {31'b0, stall}, 32'h0);
      chk("req_idle_strobes", {29'b0, dm_we, io_we, io_rd}, 32'h0);
      if (bad) ref_err = 1'b1;
    end else if (io && we) begin
      chk("io_st_strobes", {29'b0, dm_we, io_we, io_rd}, 32'h2);
      chk("io_st_stall", {31'b0, stall}, 32'h0);
      chk("io_st_addr", {24'b0, io_addr}, {24'b0, a[7:0]});
      chk("io_st_dout", io_dout, wd);
    end else if (io) begin
      chk("io_ld_strobes", {29'b0, dm_we, io_we, io_rd}, 32'h1);
      chk("io_ld_stall", {31'b0, stall}, 32'h1);
      chk("io_ld_addr", {24'b0, io_addr}, {24'b0, a[7:0]});
    end else if (we && sz == 2'b10) begin
      chk("dm_st_strobes", {29'b0, dm_we, io_we, io_rd}, 32'h4);
      chk("dm_st_stall", {31'b0, stall}, 32'h0);
      chk("dm_st_addr", {24'b0, dm_addr}, {24'b0, idx});
      chk("dm_st_wdata", dm_wdata, wd);
    end else begin
      chk("dm_2cyc_strobes", {29'b0, dm_we, io_we, io_rd}, 32'h0);
      chk("dm_2cyc_stall", {31'b0, stall}, 32'h1);
      chk("dm_2cyc_addr", {24'b0, dm_addr}, {24'b0, idx});
    end

    if (two) begin
      @(posedge clk); #1;
      io_din = ~iod;
      @(negedge clk);
      chk("c2_stall", {31'b0, stall}, 32'h0);
      chk("c2_io_strobes", {30'b0, io_we, io_rd}, 32'h0);
      if (re) begin
        exp_ld = io ? iod : model_load(ref_mem[idx], a[1:0], sz, u);
        got = mem_rdata;
        chk("c2_load_data", mem_rdata, exp_ld);
        ref_hold = exp_ld;
      end else begin
        chk("c2_rmw_we", {31'b0, dm_we}, 32'h1);
        chk("c2_rmw_addr", {24'b0, dm_addr}, {24'b0, idx});
      end
    end

    if (we && !io && !bad) ref_mem[idx] = model_store(ref_mem[idx], a[1:0], sz, wd);

    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'h0, 2'b10, 1'b0, 32'h0);
    @(negedge clk);
    chk("post_err", {31'b0, err}, {31'b0, ref_err});
    chk("post_hold", mem_rdata, ref_hold);
    chk("post_quiet", {28'b0, stall, dm_we, io_we, io_rd}, 32'h0);
    if (we && !io && !bad) chk("post_mem", dmem[idx], ref_mem[idx]);
  endtask

  initial begin
    logic [31:0] got, a, wd;
    logic [1:0]  sz;
    logic        we, re, io;
    int          r;

    rst = 1'b1;
    io_din = 32'h0;
    ref_err = 1'b0;
    ref_hold = 32'h0;
    drive(1'b0, 1'b0, 32'h0, 2'b10, 1'b0, 32'h0);
    do_reset();

    // Fill the memory through word stores so bench memory and model agree
    for (int i = 0; i < 256; i++) begin
      access(1'b1, 1'b0, i * 4, 2'b10, 1'b0, $urandom, 32'h0, got);
    end

    // Sub-word loads from 0x8081F2F3
    access(1'b1, 1'b0, 32'h14, 2'b10, 1'b0, 32'h8081_F2F3, 32'h0, got);
    access(1'b0, 1'b1, 32'h15, 2'b00, 1'b0, 32'h0, 32'h0, got);
    chk("lit_lb_15", got, 32'hFFFF_FFF2);
    access(1'b0, 1'b1, 32'h15, 2'b00, 1'b1, 32'h0, 32'h0, got);
    chk("lit_lbu_15", got, 32'h0000_00F2);
    access(1'b0, 1'b1, 32'h16, 2'b01, 1'b0, 32'h0, 32'h0, got);
    chk("lit_lh_16", got, 32'hFFFF_8081);

    // Word store then word load
    access(1'b1, 1'b0, 32'h14, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'h0, got);
    access(1'b0, 1'b1, 32'h14, 2'b10, 1'b0, 32'h0, 32'h0, got);
    chk("lit_lw_14", got, 32'hDEAD_BEEF);

    // Byte store read-modify-write
    access(1'b1, 1'b0, 32'h14, 2'b10, 1'b0, 32'h1122_3344, 32'h0, got);
    access(1'b1, 1'b0, 32'h16, 2'b00, 1'b0, 32'h0000_00AA, 32'h0, got);
    chk("lit_sb_word5", dmem[5], 32'h11AA_3344);

    // IO load and IO store
    access(1'b0, 1'b1, 32'h7F14, 2'b10, 1'b0, 32'h0, 32'h0000_1234, got);
    chk("lit_io_ld", got, 32'h0000_1234);
    access(1'b1, 1'b0, 32'h7F00, 2'b10, 1'b0, 32'h0000_00FF, 32'h0, got);

    // Errors
    access(1'b0, 1'b1, 32'h13, 2'b01, 1'b0, 32'h0, 32'h0, got);
    chk("lit_err_half_13", {31'b0, err}, 32'h1);
    do_reset();
    access(1'b0, 1'b1, 32'h7F04, 2'b00, 1'b0, 32'h0, 32'h0, got);
    chk("lit_err_io_byte", {31'b0, err}, 32'h1);
    do_reset();

    // Reset during RMW_WR: the pending write must be dropped
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 32'h14, 2'b00, 1'b0, 32'h0000_0055);
    @(negedge clk);
    chk("rmw_rst_stall1", {31'b0, stall}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rmw_rst_stall", {31'b0, stall}, 32'h0);
    chk("rmw_rst_we", {31'b0, dm_we}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    ref_err = 1'b0;
    ref_hold = 32'h0;
    drive(1'b0, 1'b0, 32'h0, 2'b10, 1'b0, 32'h0);
    @(negedge clk);
    chk("rmw_rst_mem", dmem[5], 32'h11AA_3344);
    chk("rmw_rst_rdata", mem_rdata, 32'h0);

    // Randomized accesses
    for (int n = 0; n < 400; n++) begin
      r  = $urandom_range(0, 99);
      we = (r < 50) || (r >= 90 && r < 94);
      re = (r < 45) ? 1'b0 : ((r < 50) ? 1'b0 : ((r < 90) ? 1'b1 : (r < 94)));
      if (r < 45)      begin we = 1'b0; re = 1'b1; end
      else if (r < 90) begin we = 1'b1; re = 1'b0; end
      io = ($urandom_range(0, 4) == 0);
      r  = $urandom_range(0, 9);
      sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      if (io && $urandom_range(0, 4) != 0) sz = 2'b10;
      a  = io ? {24'h00_007F, 8'($urandom)} : {20'h0, 12'($urandom)};
      if ($urandom_range(0, 9) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      wd = $urandom;
      access(we, re, a, sz, 1'($urandom), wd, $urandom, got);
      if (n % 80 == 79) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
